current_sense_calib: RTL and testbench

Front-end current stage that feeds ia/ib/ic and calib_done into the FOC core.
- Takes raw unsigned ADC phase samples.
- After reset, or on request, measures the zero-current offset of each channel by averaging.
- Sanity-checks the offsets.
- Then streams offset-removed, scaled, saturated signed 16-bit currents.
- Latches an overcurrent fault.

---
 rtl/foc_pkg.sv | 35 +++
 rtl/cs_chan.sv | 69 ++++++
 rtl/current_sense_calib.sv | 207 ++++++++++++++++++++
 tb/tb_current_sense_calib.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : foc_pkg
//  Purpose  : Shared types, state encoding and saturation helper for the
//             FOC current front end.
//  Revision : 1.0 - initial release
// ============================================================================
package foc_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_ERR    = 3'd3,
        ST_RUN    = 3'd4
    } cs_state_t;

    localparam int c_CUR_W = 16;

    typedef logic signed [c_CUR_W-1:0] cur_t;

    function automatic cur_t sat16(input logic signed [31:0] x);
        cur_t r;
        if (x > 32'sd32767) begin
            r = 16'sh7fff;
        end else if (x < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_chan.sv
`default_nettype none
// ============================================================================
//  Module   : cs_chan
//  Purpose  : One phase channel: offset accumulator, offset register,
//             offset removal with gain/saturation and overcurrent compare.
//  Revision : 1.0 - initial release
// ============================================================================
module cs_chan
    import foc_pkg::*;
#(
    parameter int          ADC_W      = 12,
    parameter int          AVG_LOG2   = 10,
    parameter int          GAIN_SHIFT = 4,
    parameter logic [15:0] OC_LIMIT   = 16'd30000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_acc_en,
    input  logic             i_load_off,
    input  logic [ADC_W-1:0] i_adc,
    output logic [ADC_W-1:0] o_off_now,
    output cur_t             o_s,
    output logic             o_oc
);

    localparam int c_ACC_W = ADC_W + AVG_LOG2;

    logic [c_ACC_W-1:0]      r_acc;
    logic [ADC_W-1:0]        r_off;
    logic signed [ADC_W:0]   w_d;
    logic signed [31:0]      w_shifted;
    logic [16:0]             w_s_ext;
    logic [16:0]             w_mag;
    logic                    w_unused_acc_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + {{AVG_LOG2{1'b0}}, i_adc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off <= '0;
        end else if (i_load_off) begin
            r_off <= o_off_now;
        end
    end

    // Truncating average: the fractional bits are simply dropped.
    assign o_off_now        = r_acc[c_ACC_W-1:AVG_LOG2];
    assign w_unused_acc_lsb = ^r_acc[AVG_LOG2-1:0];

    assign w_d       = $signed({1'b0, i_adc}) - $signed({1'b0, r_off});
    assign w_shifted = {{(31-ADC_W){w_d[ADC_W]}}, w_d} <<< GAIN_SHIFT;
    assign o_s       = sat16(w_shifted);

    // Magnitude needs 17 bits so that -32768 compares correctly.
    assign w_s_ext = {o_s[15], o_s};
    assign w_mag   = o_s[15] ? (17'd0 - w_s_ext) : w_s_ext;
    assign o_oc    = (w_mag > {1'b0, OC_LIMIT});

endmodule
`default_nettype wire

// File: rtl/current_sense_calib.sv
`default_nettype none
// ============================================================================
//  Module   : current_sense_calib
//  Purpose  : ADC phase-current front end: offset calibration, sanity check,
//             scaled/saturated current streaming and overcurrent latch.
//  Revision : 1.0 - initial release
// ============================================================================
module current_sense_calib
    import foc_pkg::*;
#(
    parameter int               ADC_W      = 12,
    parameter int               AVG_LOG2   = 10,
    parameter int               SETTLE_N   = 16,
    parameter int               GAIN_SHIFT = 4,
    parameter logic [ADC_W-1:0] OFF_MIN    = ADC_W'(1843),
    parameter logic [ADC_W-1:0] OFF_MAX    = ADC_W'(2253),
    parameter logic [15:0]      OC_LIMIT   = 16'd30000,
    parameter bit               IC_CALC    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_a,
    input  logic [ADC_W-1:0] adc_b,
    input  logic [ADC_W-1:0] adc_c,
    input  logic             recal,
    input  logic             fault_clr,
    output logic [15:0]      ia,
    output logic [15:0]      ib,
    output logic [15:0]      ic,
    output logic             i_valid,
    output logic             calib_done,
    output logic             calib_err,
    output logic             oc_fault
);

    localparam int c_SETTLE_BITS = $clog2(SETTLE_N + 1);
    localparam int c_CNT_W       = (c_SETTLE_BITS > AVG_LOG2 + 1) ? c_SETTLE_BITS : AVG_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_N - 1);
    localparam logic [c_CNT_W-1:0] c_ACCUM_LAST  = c_CNT_W'((1 << AVG_LOG2) - 1);

    cs_state_t          r_state;
    cs_state_t          w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_clr;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_acc_en;
    logic               w_load_off;
    logic               w_run_sample;
    logic               w_off_ok;
    logic               w_ok_a;
    logic               w_ok_b;
    logic               w_ok_c;
    logic               w_oc_c;
    logic               w_oc_any;
    logic [ADC_W-1:0]   w_off_a;
    logic [ADC_W-1:0]   w_off_b;
    logic [ADC_W-1:0]   w_off_c;
    cur_t               w_s_a;
    cur_t               w_s_b;
    cur_t               w_s_c;
    cur_t               w_ic;
    logic               w_oc_a;
    logic               w_oc_b;
    logic               w_oc_chan_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_acc_en   = 1'b0;
        w_load_off = 1'b0;
        if (recal) begin
            w_next = ST_SETTLE;
            w_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (adc_valid) begin
                        if (r_cnt == c_SETTLE_LAST) begin
                            w_next = ST_ACCUM;
                            w_clr  = 1'b1;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (adc_valid) begin
                        w_acc_en = 1'b1;
                        if (r_cnt == c_ACCUM_LAST) begin
                            w_next    = ST_CHECK;
                            w_cnt_clr = 1'b1;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    w_load_off = 1'b1;
                    w_next     = w_off_ok ? ST_RUN : ST_ERR;
                end
                ST_ERR:  w_next = ST_ERR;
                ST_RUN:  w_next = ST_RUN;
                default: w_next = ST_SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clr || w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    cs_chan #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .GAIN_SHIFT(GAIN_SHIFT), .OC_LIMIT(OC_LIMIT)) u_chan_a (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc_en(w_acc_en), .i_load_off(w_load_off),
        .i_adc(adc_a), .o_off_now(w_off_a), .o_s(w_s_a), .o_oc(w_oc_a)
    );

    cs_chan #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .GAIN_SHIFT(GAIN_SHIFT), .OC_LIMIT(OC_LIMIT)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc_en(w_acc_en), .i_load_off(w_load_off),
        .i_adc(adc_b), .o_off_now(w_off_b), .o_s(w_s_b), .o_oc(w_oc_b)
    );

    cs_chan #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .GAIN_SHIFT(GAIN_SHIFT), .OC_LIMIT(OC_LIMIT)) u_chan_c (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_acc_en(w_acc_en), .i_load_off(w_load_off),
        .i_adc(adc_c), .o_off_now(w_off_c), .o_s(w_s_c), .o_oc(w_oc_chan_c)
    );

    assign w_ok_a = (w_off_a >= OFF_MIN) && (w_off_a <= OFF_MAX);
    assign w_ok_b = (w_off_b >= OFF_MIN) && (w_off_b <= OFF_MAX);

    generate
        if (IC_CALC) begin : g_ic_calc
            logic signed [17:0] w_sum;
            logic signed [17:0] w_neg;
            logic               w_unused_c;
            // Derived from the already saturated A/B values, so the sum fits 18 bits.
            assign w_sum      = {{2{w_s_a[15]}}, w_s_a} + {{2{w_s_b[15]}}, w_s_b};
            assign w_neg      = 18'sd0 - w_sum;
            assign w_ic       = sat16({{14{w_neg[17]}}, w_neg});
            assign w_oc_c     = 1'b0;
            assign w_ok_c     = 1'b1;
            assign w_unused_c = ^{w_s_c, w_oc_chan_c, w_off_c};
        end else begin : g_ic_adc
            assign w_ic   = w_s_c;
            assign w_oc_c = w_oc_chan_c;
            assign w_ok_c = (w_off_c >= OFF_MIN) && (w_off_c <= OFF_MAX);
        end
    endgenerate

    assign w_off_ok     = w_ok_a && w_ok_b && w_ok_c;
    assign w_oc_any     = w_oc_a || w_oc_b || w_oc_c;
    assign w_run_sample = (r_state == ST_RUN) && adc_valid && !recal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ia      <= '0;
            ib      <= '0;
            ic      <= '0;
            i_valid <= 1'b0;
        end else if (recal) begin
            ia      <= '0;
            ib      <= '0;
            ic      <= '0;
            i_valid <= 1'b0;
        end else begin
            i_valid <= w_run_sample;
            if (w_run_sample) begin
                ia <= w_s_a;
                ib <= w_s_b;
                ic <= w_ic;
            end
        end
    end

    // A new overcurrent takes priority over a coincident clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_fault <= 1'b0;
        end else if (w_run_sample && w_oc_any) begin
            oc_fault <= 1'b1;
        end else if (fault_clr) begin
            oc_fault <= 1'b0;
        end
    end

    assign calib_done = (r_state == ST_RUN);
    assign calib_err  = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_current_sense_calib.sv
`default_nettype none
// ============================================================================
//  Module   : tb_current_sense_calib
//  Purpose  : Randomised scoreboard bench for current_sense_calib.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_current_sense_calib;

    localparam int SETTLE_N = 2;
    localparam int AVG_N    = 16;
    localparam int M_SETTLE = 0;
    localparam int M_ACCUM  = 1;
    localparam int M_CHECK  = 2;
    localparam int M_ERR    = 3;
    localparam int M_RUN    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_a = '0;
    logic [11:0] adc_b = '0;
    logic [11:0] adc_c = '0;
    logic        recal = 1'b0;
    logic        fault_clr = 1'b0;
    logic [15:0] ia;
    logic [15:0] ib;
    logic [15:0] ic;
    logic        i_valid;
    logic        calib_done;
    logic        calib_err;
    logic        oc_fault;

    always #5 clk = ~clk;

    current_sense_calib #(.AVG_LOG2(4), .SETTLE_N(SETTLE_N)) dut (
        .clk(clk), .rst_n(rst_n), .adc_valid(adc_valid),
        .adc_a(adc_a), .adc_b(adc_b), .adc_c(adc_c),
        .recal(recal), .fault_clr(fault_clr),
        .ia(ia), .ib(ib), .ic(ic), .i_valid(i_valid),
        .calib_done(calib_done), .calib_err(calib_err), .oc_fault(oc_fault)
    );

    typedef struct {
        int a;
        int b;
        int c;
        bit oc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;

    int   m_mode = M_SETTLE;
    int   m_cnt  = 0;
    int   m_sum[3];
    int   m_off[3];
    bit   m_oc   = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit in_range(input int v);
        return (v >= 1843) && (v <= 2253);
    endfunction

    task automatic model_reset();
        m_mode = M_SETTLE;
        m_cnt  = 0;
        m_oc   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0;
            m_off[k] = 0;
        end
        q.delete();
    endtask

    // Reference behaviour for one clock edge, written from the calibration rules.
    task automatic model_edge(input bit v, input int a, input int b, input int c,
                              input bit rc, input bit fc);
        bit   new_oc = 1'b0;
        bit   push   = 1'b0;
        exp_t e;
        e = '{0, 0, 0, 1'b0};
        if (rc) begin
            m_mode = M_SETTLE;
            m_cnt  = 0;
            for (int k = 0; k < 3; k++) m_sum[k] = 0;
        end else begin
            case (m_mode)
                M_SETTLE: if (v) begin
                    m_cnt++;
                    if (m_cnt == SETTLE_N) begin
                        m_mode = M_ACCUM;
                        m_cnt  = 0;
                        for (int k = 0; k < 3; k++) m_sum[k] = 0;
                    end
                end
                M_ACCUM: if (v) begin
                    m_sum[0] += a;
                    m_sum[1] += b;
                    m_sum[2] += c;
                    m_cnt++;
                    if (m_cnt == AVG_N) m_mode = M_CHECK;
                end
                M_CHECK: begin
                    for (int k = 0; k < 3; k++) m_off[k] = m_sum[k] / AVG_N;
                    m_mode = (in_range(m_off[0]) && in_range(m_off[1])) ? M_RUN : M_ERR;
                end
                M_RUN: if (v) begin
                    e.a    = sat((a - m_off[0]) * 16);
                    e.b    = sat((b - m_off[1]) * 16);
                    e.c    = sat(-(e.a + e.b));
                    new_oc = (iabs(e.a) > 30000) || (iabs(e.b) > 30000);
                    push   = 1'b1;
                end
                default: ;
            endcase
        end
        if (new_oc) m_oc = 1'b1;
        else if (fc) m_oc = 1'b0;
        if (push) begin
            e.oc = m_oc;
            q.push_back(e);
        end
    endtask

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic tick(input bit v, input int a, input int b, input int c,
                        input bit rc, input bit fc);
        adc_valid = v;
        adc_a     = a[11:0];
        adc_b     = b[11:0];
        adc_c     = c[11:0];
        recal     = rc;
        fault_clr = fc;
        @(posedge clk);
        model_edge(v, a, b, c, rc, fc);
        @(negedge clk);
        adc_valid = 1'b0;
        recal     = 1'b0;
        fault_clr = 1'b0;
        chk("calib_done", int'(calib_done), int'(m_mode == M_RUN));
        chk("calib_err", int'(calib_err), int'(m_mode == M_ERR));
        chk("oc_fault", int'(oc_fault), int'(m_oc));
        if (m_mode != M_RUN) chk("ia_idle_zero", int'($signed(ia)), 0);
    endtask

    task automatic strobe(input int a, input int b, input int c);
        tick(1'b1, a, b, c, 1'b0, 1'b0);
        tick(1'b0, a, b, c, 1'b0, 1'b0);
    endtask

    task automatic calibrate(input int a, input int b, input int c);
        repeat (SETTLE_N + AVG_N) strobe(a, b, c);
    endtask

    always @(posedge clk) begin
        #1;
        if (i_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_i_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("ia", int'($signed(ia)), mon_e.a);
                chk("ib", int'($signed(ib)), mon_e.b);
                chk("ic", int'($signed(ic)), mon_e.c);
                chk("oc_at_sample", int'(oc_fault), int'(mon_e.oc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba;
        int bb;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ia", int'(ia), 0);
        chk("rst_ib", int'(ib), 0);
        chk("rst_ic", int'(ic), 0);
        chk("rst_i_valid", int'(i_valid), 0);
        chk("rst_calib_done", int'(calib_done), 0);
        chk("rst_calib_err", int'(calib_err), 0);
        chk("rst_oc_fault", int'(oc_fault), 0);
        rst_n = 1'b1;

        // Constant calibration, then zero currents.
        for (int i = 1; i <= 30; i++) strobe(2048, 2050, 2040);
        chk("t1_done", int'(calib_done), 1);

        // Scaling and boundary values with offset 2048.
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        calibrate(2048, 2048, 2048);
        strobe(2148, 1948, 2048);
        strobe(4095, 2048, 2048);
        strobe(0, 2048, 2048);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("hold_ia", int'($signed(ia)), -32768);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b1);

        // Offset out of range.
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        calibrate(2048, 1500, 2048);
        chk("t3_err", int'(calib_err), 1);
        repeat (3) strobe(2100, 2100, 2100);
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        calibrate(2048, 2048, 2048);
        chk("t3_recovered", int'(calib_done), 1);

        // Overcurrent latch behaviour.
        strobe(4095, 2048, 2048);
        chk("t4_oc_set", int'(oc_fault), 1);
        repeat (3) strobe(2100, 2000, 2048);
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t4_oc_after_recal", int'(oc_fault), 1);
        calibrate(2048, 2048, 2048);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("t4_oc_cleared", int'(oc_fault), 0);
        tick(1'b1, 4095, 2048, 2048, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t4_set_wins", int'(oc_fault), 1);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b1);

        // recal coincident with a strobe mid-accumulation.
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        repeat (SETTLE_N + 5) strobe(2048, 2048, 2048);
        tick(1'b1, 0, 0, 0, 1'b1, 1'b0);
        tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (SETTLE_N + AVG_N - 1) strobe(2100, 2000, 2048);
        chk("t5_not_yet", int'(calib_done), 0);
        strobe(2100, 2000, 2048);
        chk("t5_done", int'(calib_done), 1);
        strobe(2110, 1990, 2048);

        // Randomised calibration and streaming.
        for (int r = 0; r < 3; r++) begin
            tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
            ba = int'($urandom_range(1830, 2265));
            bb = int'($urandom_range(1830, 2265));
            repeat (SETTLE_N + AVG_N)
                strobe(ba + int'($urandom_range(0, 16)) - 8, bb + int'($urandom_range(0, 16)) - 8, 2048);
            for (int i = 0; i < 150; i++) begin
                tick(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 4095)), 1'b0, ($urandom_range(0, 7) == 0));
                tick(1'b0, 0, 0, 0, 1'b0, ($urandom_range(0, 7) == 0));
            end
        end

        // Asynchronous reset while streaming.
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        calibrate(2048, 2048, 2048);
        strobe(4095, 2048, 2048);
        strobe(2148, 1948, 2048);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ia", int'(ia), 0);
        chk("async_ib", int'(ib), 0);
        chk("async_calib_done", int'(calib_done), 0);
        chk("async_oc_fault", int'(oc_fault), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        calibrate(2048, 2048, 2048);
        chk("t6_done", int'(calib_done), 1);
        strobe(2148, 1948, 2048);

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
